// File: rtl/psram_bus_bridge.sv
// Two-requester front end for the psram64 controller: loader writes and Z80 accesses
// share the single-byte rd/we/ready port; repeat CPU reads can be served from a one-byte cache.
module psram_bus_bridge #(
  parameter int AW       = 23,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_wait_n,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_rd,
  output logic          mem_we,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {WAIT_INIT, IDLE, ISSUE, WAIT_DONE} state_t;

  state_t state_reg, state_next;

  logic          cpu_rd_q_reg, cpu_wr_q_reg;
  logic          cpu_pend_reg, cpu_op_wr_reg;
  logic [AW-1:0] cpu_addr_reg;
  logic [7:0]    cpu_data_reg;
  logic [7:0]    cpu_din_reg;
  logic          cpu_wait_n_reg;
  logic          ld_full_reg;
  logic [AW-1:0] ld_addr_reg;
  logic [7:0]    ld_data_reg;
  logic          op_wr_reg, op_cpu_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [7:0]    mem_din_reg;
  logic          cache_valid_reg;
  logic [AW-1:0] cache_addr_reg;
  logic [7:0]    cache_data_reg;

  logic rd_edge, wr_edge, cpu_edge, cache_hit, ld_accept;
  logic start_ld, start_cpu, done;

  // A new CPU edge is only accepted once the previous one has been fully served.
  assign rd_edge   = cpu_rd & ~cpu_rd_q_reg;
  assign wr_edge   = cpu_wr & ~cpu_wr_q_reg;
  assign cpu_edge  = (rd_edge | wr_edge) & ~cpu_pend_reg;
  assign cache_hit = CACHE_EN && rd_edge && !wr_edge && cache_valid_reg &&
                     (cache_addr_reg == cpu_addr);
  assign ld_accept = ioctl_wr & ~ld_full_reg;

  always_comb begin
    state_next = state_reg;
    start_ld   = 1'b0;
    start_cpu  = 1'b0;
    done       = 1'b0;
    case (state_reg)
      WAIT_INIT: if (mem_ready) state_next = IDLE;
      IDLE: begin
        if (ld_full_reg) begin
          start_ld   = 1'b1;
          state_next = ISSUE;
        end else if (cpu_pend_reg) begin
          start_cpu  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: if (!mem_ready) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (mem_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    // Edge history keeps tracking through reset so a strobe held across it does not re-fire.
    cpu_rd_q_reg <= cpu_rd;
    cpu_wr_q_reg <= cpu_wr;
    if (reset) begin
      state_reg       <= WAIT_INIT;
      cpu_pend_reg    <= 1'b0;
      cpu_wait_n_reg  <= 1'b1;
      cpu_din_reg     <= 8'h00;
      ld_full_reg     <= 1'b0;
      cache_valid_reg <= 1'b0;
      mem_addr_reg    <= '0;
      mem_din_reg     <= 8'h00;
      op_wr_reg       <= 1'b0;
      op_cpu_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (cpu_edge) begin
        if (cache_hit) begin
          cpu_din_reg <= cache_data_reg;
        end else begin
          cpu_pend_reg   <= 1'b1;
          cpu_wait_n_reg <= 1'b0;
          cpu_op_wr_reg  <= wr_edge;
          cpu_addr_reg   <= cpu_addr;
          cpu_data_reg   <= cpu_dout;
        end
      end

      if (ld_accept) begin
        ld_full_reg <= 1'b1;
        ld_addr_reg <= ioctl_addr;
        ld_data_reg <= ioctl_dout;
      end

      if (start_ld) begin
        mem_addr_reg <= ld_addr_reg;
        mem_din_reg  <= ld_data_reg;
        op_wr_reg    <= 1'b1;
        op_cpu_reg   <= 1'b0;
        ld_full_reg  <= 1'b0;
        if (ld_addr_reg == cache_addr_reg) cache_valid_reg <= 1'b0;
      end

      if (start_cpu) begin
        mem_addr_reg <= cpu_addr_reg;
        mem_din_reg  <= cpu_data_reg;
        op_wr_reg    <= cpu_op_wr_reg;
        op_cpu_reg   <= 1'b1;
        if (cpu_op_wr_reg && cache_valid_reg && (cache_addr_reg == cpu_addr_reg))
          cache_data_reg <= cpu_data_reg;
      end

      if (done) begin
        if (!op_wr_reg) begin
          cpu_din_reg     <= mem_dout;
          cache_valid_reg <= 1'b1;
          cache_addr_reg  <= mem_addr_reg;
          cache_data_reg  <= mem_dout;
        end
        if (op_cpu_reg) begin
          cpu_pend_reg   <= 1'b0;
          cpu_wait_n_reg <= 1'b1;
        end
      end

      // An accepted loader byte kills a matching entry, including one being filled this cycle.
      if (ld_accept && (((done && !op_wr_reg) ? mem_addr_reg : cache_addr_reg) == ioctl_addr))
        cache_valid_reg <= 1'b0;
    end
  end

  assign mem_rd     = (state_reg == ISSUE) && !op_wr_reg;
  assign mem_we     = (state_reg == ISSUE) && op_wr_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_din    = mem_din_reg;
  assign cpu_din    = cpu_din_reg;
  assign cpu_wait_n = cpu_wait_n_reg;
  assign ioctl_wait = ld_full_reg;

endmodule

// File: tb/tb_psram_bus_bridge.sv
// Directed bench for psram_bus_bridge: a cached instance plus an uncached one, each
// driven against a small psram64-like ready/strobe model.
module tb_psram_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic        cpu_wait_n;
  logic        ioctl_wr = 1'b0;
  logic [22:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        ioctl_wait;
  logic [22:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_rd, mem_we;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_ready;

  logic        nc_cpu_rd = 1'b0;
  logic [22:0] nc_cpu_addr = '0;
  logic [7:0]  nc_cpu_din;
  logic        nc_cpu_wait_n;
  logic        nc_ioctl_wait;
  logic [22:0] nc_mem_addr;
  logic [7:0]  nc_mem_din;
  logic        nc_mem_rd, nc_mem_we;
  logic [7:0]  nc_mem_dout = 8'h00;
  logic        nc_mem_ready;

  psram_bus_bridge #(.AW(23), .CACHE_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_wait_n(cpu_wait_n),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  psram_bus_bridge #(.AW(23), .CACHE_EN(1'b0)) u_dut_nc (
    .clk(clk), .reset(reset),
    .cpu_rd(nc_cpu_rd), .cpu_wr(1'b0), .cpu_addr(nc_cpu_addr), .cpu_dout(8'h00),
    .cpu_din(nc_cpu_din), .cpu_wait_n(nc_cpu_wait_n),
    .ioctl_wr(1'b0), .ioctl_addr(23'h0), .ioctl_dout(8'h00), .ioctl_wait(nc_ioctl_wait),
    .mem_addr(nc_mem_addr), .mem_din(nc_mem_din), .mem_rd(nc_mem_rd), .mem_we(nc_mem_we),
    .mem_dout(nc_mem_dout), .mem_ready(nc_mem_ready)
  );

  // Controller model: a strobe rising edge drops ready for 4 cycles; unwritten bytes read addr[7:0]^0x5A.
  logic        init_hold = 1'b1;
  logic        model_ready = 1'b1;
  int          busy = 0;
  logic        rd_q = 1'b0, we_q = 1'b0;
  int          rd_count = 0, we_count = 0, seq = 0, rd_seq = 0, we_seq = 0;
  logic [22:0] last_rd_addr = '0, last_we_addr = '0;
  logic [7:0]  last_we_data = 8'h00;
  bit          strobe_in_init = 1'b0;
  logic [7:0]  pmem [4096];
  bit          pvalid [4096];

  assign mem_ready = model_ready & ~init_hold;

  always @(posedge clk) begin
    rd_q <= mem_rd;
    we_q <= mem_we;
    if (init_hold && (mem_rd || mem_we)) strobe_in_init <= 1'b1;
    if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) model_ready <= 1'b1;
    end else if (mem_rd && !rd_q) begin
      rd_count     <= rd_count + 1;
      seq          <= seq + 1;
      rd_seq       <= seq;
      last_rd_addr <= mem_addr;
      model_ready  <= 1'b0;
      busy         <= 4;
      mem_dout     <= pvalid[mem_addr[11:0]] ? pmem[mem_addr[11:0]] : (mem_addr[7:0] ^ 8'h5A);
    end else if (mem_we && !we_q) begin
      we_count     <= we_count + 1;
      seq          <= seq + 1;
      we_seq       <= seq;
      last_we_addr <= mem_addr;
      last_we_data <= mem_din;
      model_ready  <= 1'b0;
      busy         <= 4;
      pmem[mem_addr[11:0]]   <= mem_din;
      pvalid[mem_addr[11:0]] <= 1'b1;
    end
  end

  logic nc_model_ready = 1'b1;
  int   nc_busy = 0;
  logic nc_rd_q = 1'b0;
  int   nc_rd_count = 0;

  assign nc_mem_ready = nc_model_ready;

  always @(posedge clk) begin
    nc_rd_q <= nc_mem_rd;
    if (nc_busy != 0) begin
      nc_busy <= nc_busy - 1;
      if (nc_busy == 1) nc_model_ready <= 1'b1;
    end else if (nc_mem_rd && !nc_rd_q) begin
      nc_rd_count    <= nc_rd_count + 1;
      nc_model_ready <= 1'b0;
      nc_busy        <= 4;
      nc_mem_dout    <= nc_mem_addr[7:0] ^ 8'h5A;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cpu(input int limit);
    for (int i = 0; i < limit && cpu_wait_n !== 1'b1; i++) tick(1);
  endtask

  task automatic wait_nc(input int limit);
    for (int i = 0; i < limit && nc_cpu_wait_n !== 1'b1; i++) tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, we0;

    // Reset values
    tick(3);
    $display("step reset: checking reset outputs");
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_wait_n", cpu_wait_n, 1'b1);
    check("rst_cpu_din", cpu_din, 8'h00);
    check("rst_ioctl_wait", ioctl_wait, 1'b0);
    check("rst_mem_addr", mem_addr, 23'h0);
    check("rst_mem_din", mem_din, 8'h00);
    reset = 1'b0;
    tick(5);

    // 1: read requested while controller still initialising
    $display("step 1: cpu_rd 0x000100 during init");
    rd0 = rd_count;
    cpu_addr = 23'h000100;
    cpu_rd   = 1'b1;
    tick(1);
    check("t1_wait_low", cpu_wait_n, 1'b0);
    tick(44);
    check("t1_no_strobe_init", strobe_in_init, 1'b0);
    check("t1_rd_idle", mem_rd, 1'b0);
    init_hold = 1'b0;
    tick(1);
    wait_cpu(100);
    check("t1_wait_done", cpu_wait_n, 1'b1);
    check("t1_cpu_din", cpu_din, 8'h5A);
    check("t1_rd_pulses", rd_count - rd0, 1);
    check("t1_rd_addr", last_rd_addr, 23'h000100);
    cpu_rd = 1'b0;
    tick(2);

    // 2: write to top of memory
    $display("step 2: cpu_wr 0x3C to 0x7FFFFF");
    we0 = we_count;
    cpu_addr = 23'h7FFFFF;
    cpu_dout = 8'h3C;
    cpu_wr   = 1'b1;
    tick(1);
    check("t2_wait_low", cpu_wait_n, 1'b0);
    wait_cpu(100);
    check("t2_wait_done", cpu_wait_n, 1'b1);
    check("t2_release_ready", mem_ready, 1'b1);
    check("t2_we_pulses", we_count - we0, 1);
    check("t2_we_addr", last_we_addr, 23'h7FFFFF);
    check("t2_we_data", last_we_data, 8'h3C);
    cpu_wr = 1'b0;
    tick(2);

    // 3: cache hits, write-through, loader invalidation
    $display("step 3: repeat reads of 0x000100");
    rd0 = rd_count;
    cpu_addr = 23'h000100;
    cpu_rd   = 1'b1;
    tick(1);
    check("t3_hit1_wait", cpu_wait_n, 1'b1);
    check("t3_hit1_din", cpu_din, 8'h5A);
    cpu_rd = 1'b0;
    tick(1);
    cpu_rd = 1'b1;
    tick(1);
    check("t3_hit2_wait", cpu_wait_n, 1'b1);
    cpu_rd = 1'b0;
    tick(5);
    check("t3_hit_no_rd", rd_count - rd0, 0);

    $display("step 3b: write-through 0x66 to 0x000100 then read");
    cpu_dout = 8'h66;
    cpu_wr   = 1'b1;
    tick(1);
    wait_cpu(100);
    cpu_wr = 1'b0;
    tick(2);
    cpu_rd = 1'b1;
    tick(1);
    check("t3_wt_wait", cpu_wait_n, 1'b1);
    check("t3_wt_din", cpu_din, 8'h66);
    cpu_rd = 1'b0;
    tick(3);
    check("t3_wt_no_rd", rd_count - rd0, 0);

    $display("step 3c: loader 0x77 to 0x000100 then read");
    ioctl_addr = 23'h000100;
    ioctl_dout = 8'h77;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    check("t3_ld_wait", ioctl_wait, 1'b1);
    tick(15);
    check("t3_ld_data", last_we_data, 8'h77);
    check("t3_ld_wait_clr", ioctl_wait, 1'b0);
    cpu_rd = 1'b1;
    tick(1);
    check("t3_miss_wait", cpu_wait_n, 1'b0);
    wait_cpu(100);
    check("t3_miss_rd", rd_count - rd0, 1);
    check("t3_miss_din", cpu_din, 8'h77);
    cpu_rd = 1'b0;
    tick(2);

    // 4: loader and CPU read in the same cycle
    $display("step 4: ioctl_wr 0x001000/0xAA with cpu_rd 0x001000");
    rd0 = rd_count;
    we0 = we_count;
    ioctl_addr = 23'h001000;
    ioctl_dout = 8'hAA;
    ioctl_wr   = 1'b1;
    cpu_addr   = 23'h001000;
    cpu_rd     = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    check("t4_ld_wait", ioctl_wait, 1'b1);
    check("t4_cpu_wait", cpu_wait_n, 1'b0);
    tick(1);
    check("t4_we_first", mem_we, 1'b1);
    check("t4_ld_issued", ioctl_wait, 1'b0);
    check("t4_mem_addr", mem_addr, 23'h001000);
    check("t4_mem_din", mem_din, 8'hAA);
    wait_cpu(100);
    check("t4_wait_done", cpu_wait_n, 1'b1);
    check("t4_we_pulses", we_count - we0, 1);
    check("t4_rd_pulses", rd_count - rd0, 1);
    check("t4_order", (we_seq < rd_seq), 1'b1);
    check("t4_cpu_din", cpu_din, 8'hAA);
    cpu_rd = 1'b0;
    tick(2);

    // 5: long-held read, then reset during ISSUE
    $display("step 5: cpu_rd held 200 clk at 0x002034");
    rd0 = rd_count;
    cpu_addr = 23'h002034;
    cpu_rd   = 1'b1;
    tick(200);
    check("t5_one_rd", rd_count - rd0, 1);
    check("t5_wait_n", cpu_wait_n, 1'b1);
    check("t5_cpu_din", cpu_din, 8'h6E);
    cpu_rd = 1'b0;
    tick(2);

    $display("step 5b: reset while mem_rd high with loader byte pending");
    rd0 = rd_count;
    we0 = we_count;
    cpu_addr = 23'h002035;
    cpu_rd   = 1'b1;
    for (int i = 0; i < 20 && mem_rd !== 1'b1; i++) tick(1);
    check("t5_issue_seen", mem_rd, 1'b1);
    ioctl_addr = 23'h003000;
    ioctl_dout = 8'h11;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    check("t5_ld_full", ioctl_wait, 1'b1);
    check("t5_still_issue", mem_rd, 1'b1);
    reset     = 1'b1;
    init_hold = 1'b1;
    tick(1);
    check("t5_rst_rd_drop", mem_rd, 1'b0);
    check("t5_rst_ld_empty", ioctl_wait, 1'b0);
    check("t5_rst_wait_n", cpu_wait_n, 1'b1);
    reset = 1'b0;
    tick(20);
    check("t5_hold_no_rd", mem_rd, 1'b0);
    check("t5_hold_no_we", mem_we, 1'b0);
    init_hold = 1'b0;
    tick(30);
    check("t5_no_reissue_rd", rd_count - rd0, 1);
    check("t5_ld_discarded", we_count - we0, 0);
    cpu_rd = 1'b0;
    tick(2);

    // 6: uncached instance reads every edge
    $display("step 6: uncached repeat reads of 0x000100");
    nc_cpu_addr = 23'h000100;
    for (int k = 0; k < 3; k++) begin
      nc_cpu_rd = 1'b1;
      tick(1);
      check("t6_wait_low", nc_cpu_wait_n, 1'b0);
      wait_nc(100);
      check("t6_wait_done", nc_cpu_wait_n, 1'b1);
      check("t6_cpu_din", nc_cpu_din, 8'h5A);
      nc_cpu_rd = 1'b0;
      tick(2);
    end
    check("t6_rd_per_edge", nc_rd_count, 3);
    check("t6_no_we", nc_mem_we, 1'b0);
    check("t6_no_ld_wait", nc_ioctl_wait, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
